// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA/SVGA raster timing generator. Walks an (h, v) raster
//   under a pixel clock-enable and registers sync, blanking, coordinates,
//   frame/line strobes, a raster-line interrupt and a frame counter. Every
//   output describes the pixel that was just issued, one clock behind the
//   counters.
//
//   Build option: define VGA_TPG_EN to drive o_rgb with eight vertical
//   colour bars (white on the left, black on the right). Without it o_rgb
//   is tied to zero and no bar logic exists.
//
// Ports
//   i_clk          clock
//   i_rst_n        asynchronous active-low reset
//   i_ce           pixel clock-enable; the raster only advances when high
//   i_irq_line     raster line that raises o_line_irq at its first pixel
//   o_hs / o_vs    horizontal / vertical sync, active level HS_POL / VS_POL
//   o_active       current pixel is visible; o_blanking is its inverse
//   o_x / o_y      pixel column (0 when not visible) / line (clamped)
//   o_line_start   one-clock pulse at h = 0
//   o_frame_start  one-clock pulse at (0, 0)
//   o_animate      one-clock pulse at the last visible pixel
//   o_screenend    one-clock pulse at the last pixel of the frame
//   o_line_irq     one-clock pulse at (0, i_irq_line)
//   o_frame        completed-frame count, wraps at 2^FRAME_W
//   o_rgb          4:4:4 test-pattern colour

module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int X_W      = 11,
  parameter int Y_W      = 10,
  parameter int FRAME_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ce,
  input  logic [Y_W-1:0]     i_irq_line,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_active,
  output logic               o_blanking,
  output logic [X_W-1:0]     o_x,
  output logic [Y_W-1:0]     o_y,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic               o_animate,
  output logic               o_screenend,
  output logic               o_line_irq,
  output logic [FRAME_W-1:0] o_frame,
  output logic [11:0]        o_rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_VIS    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] H_ANIM   = X_W'(H_ACTIVE - 1);
  localparam logic [X_W-1:0] HS_BEGIN = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_VIS    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] V_ANIM   = Y_W'(V_ACTIVE - 1);
  localparam logic [Y_W-1:0] VS_BEGIN = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [X_W-1:0] h;
  logic [Y_W-1:0] v;
  logic           h_end;
  logic           v_end;
  logic           pix_active;
  logic           hs_on;
  logic           vs_on;

  always_comb begin
    h_end      = (h == H_LAST);
    v_end      = (v == V_LAST);
    pix_active = (h < H_VIS) && (v < V_VIS);
    hs_on      = (h >= HS_BEGIN) && (h < HS_END);
    vs_on      = (v >= VS_BEGIN) && (v < VS_END);
  end

  // Raster counters; the frame count steps on the same edge that wraps the
  // raster, so it already shows the new value while o_screenend is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h       <= '0;
      v       <= '0;
      o_frame <= '0;
    end else if (i_ce) begin
      if (h_end) begin
        h <= '0;
        if (v_end) begin
          v       <= '0;
          o_frame <= o_frame + 1'b1;
        end else begin
          v <= v + 1'b1;
        end
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Output register. Level outputs hold while i_ce is low; strobes are
  // cleared on every clock first so they can never stretch past one clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hs          <= !HS_POL;
      o_vs          <= !VS_POL;
      o_active      <= 1'b0;
      o_blanking    <= 1'b1;
      o_x           <= '0;
      o_y           <= '0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_animate     <= 1'b0;
      o_screenend   <= 1'b0;
      o_line_irq    <= 1'b0;
    end else begin
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_animate     <= 1'b0;
      o_screenend   <= 1'b0;
      o_line_irq    <= 1'b0;
      if (i_ce) begin
        o_hs          <= hs_on ? HS_POL : !HS_POL;
        o_vs          <= vs_on ? VS_POL : !VS_POL;
        o_active      <= pix_active;
        o_blanking    <= !pix_active;
        o_x           <= pix_active ? h : '0;
        o_y           <= (v < V_VIS) ? v : V_ANIM;
        o_line_start  <= (h == '0);
        o_frame_start <= (h == '0) && (v == '0);
        o_animate     <= (h == H_ANIM) && (v == V_ANIM);
        o_screenend   <= h_end && v_end;
        // v never exceeds V_TOTAL-1, so an out-of-range line never matches.
        o_line_irq    <= (h == '0) && (v == i_irq_line);
      end
    end
  end

`ifdef VGA_TPG_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar;
  logic [2:0]  bar_inv;
  logic [11:0] rgb_next;

  // Bar index by threshold compare; bar k shows the colour whose R,G,B
  // bits are those of (7-k), so bar 0 is white and bar 7 is black.
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(h) >= k * BAR_W) begin
        bar = 3'(k);
      end
    end
    bar_inv  = 3'd7 - bar;
    rgb_next = {{4{bar_inv[2]}}, {4{bar_inv[1]}}, {4{bar_inv[0]}}};
    if (!pix_active) begin
      rgb_next = 12'h000;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rgb <= 12'h000;
    end else if (i_ce) begin
      o_rgb <= rgb_next;
    end
  end
`else
  assign o_rgb = 12'h000;
`endif

`ifndef SYNTHESIS
  localparam bit SIZES_OK = (H_TOTAL <= 2 ** X_W) && (V_TOTAL <= 2 ** Y_W);

  a_sizes_cover_totals : assert property (@(posedge i_clk) SIZES_OK);
  a_counters_in_range : assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                         (h <= H_LAST) && (v <= V_LAST));
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen. Three instances share clock, reset
//   and clock-enable: the default 800x600 timing, a tiny raster (24x14,
//   2-bit frame counter) that makes whole-frame behaviour cheap to reach,
//   and a 640-wide active-low-hsync line (800 total). Expected values are
//   hand-derived pixel positions: with i_ce high every clock, the n-th edge
//   after reset release shows pixel n-1 in raster order.

module tb_vga_timing_gen;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce    = 1'b0;
  logic [9:0] irq_d = 10'd1;
  logic [9:0] irq_s = 10'd3;
  logic [9:0] irq_v = 10'd0;

  logic        hs_d, vs_d, act_d, blank_d, ls_d, fs_d, an_d, se_d, li_d;
  logic [10:0] x_d;
  logic [9:0]  y_d;
  logic [15:0] frame_d;
  logic [11:0] rgb_d;

  logic        hs_s, vs_s, act_s, blank_s, ls_s, fs_s, an_s, se_s, li_s;
  logic [10:0] x_s;
  logic [9:0]  y_s;
  logic [1:0]  frame_s;
  logic [11:0] rgb_s;

  logic        hs_v, vs_v, act_v, blank_v, ls_v, fs_v, an_v, se_v, li_v;
  logic [10:0] x_v;
  logic [9:0]  y_v;
  logic [15:0] frame_v;
  logic [11:0] rgb_v;

  int assert_count = 0;
  int fail_count   = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_irq_line(irq_d),
    .o_hs(hs_d), .o_vs(vs_d), .o_active(act_d), .o_blanking(blank_d),
    .o_x(x_d), .o_y(y_d), .o_line_start(ls_d), .o_frame_start(fs_d),
    .o_animate(an_d), .o_screenend(se_d), .o_line_irq(li_d),
    .o_frame(frame_d), .o_rgb(rgb_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .FRAME_W(2)
  ) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_irq_line(irq_s),
    .o_hs(hs_s), .o_vs(vs_s), .o_active(act_s), .o_blanking(blank_s),
    .o_x(x_s), .o_y(y_s), .o_line_start(ls_s), .o_frame_start(fs_s),
    .o_animate(an_s), .o_screenend(se_s), .o_line_irq(li_s),
    .o_frame(frame_s), .o_rgb(rgb_s)
  );

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48), .HS_POL(1'b0),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_v (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_irq_line(irq_v),
    .o_hs(hs_v), .o_vs(vs_v), .o_active(act_v), .o_blanking(blank_v),
    .o_x(x_v), .o_y(y_v), .o_line_start(ls_v), .o_frame_start(fs_v),
    .o_animate(an_v), .o_screenend(se_v), .o_line_irq(li_v),
    .o_frame(frame_v), .o_rgb(rgb_v)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Drive the clock-enable for the next edge, then sample 1 ns after it.
  task automatic applyStimulus(input logic ce_val);
    ce = ce_val;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    repeat (2) applyStimulus(1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt_a, cnt_b, cnt_c, cnt_d, cnt_e, cnt_f, cnt_g, cnt_h, cnt_i;
    int first_a, first_b, first_c, first_d, first_e, first_f;

    // ---------------- reset state ----------------
    repeat (3) applyStimulus(1'b0);
    checkOutput("rst_hs",     32'(hs_d),    32'd0);
    checkOutput("rst_vs",     32'(vs_d),    32'd0);
    checkOutput("rst_hs_neg", 32'(hs_v),    32'd1);
    checkOutput("rst_active", 32'(act_d),   32'd0);
    checkOutput("rst_blank",  32'(blank_d), 32'd1);
    checkOutput("rst_x",      32'(x_d),     32'd0);
    checkOutput("rst_y",      32'(y_d),     32'd0);
    checkOutput("rst_rgb",    32'(rgb_d),   32'd0);
    checkOutput("rst_frame",  32'(frame_d), 32'd0);
    checkOutput("rst_pulses", 32'({ls_d, fs_d, an_d, se_d, li_d}), 32'd0);

    // ---------------- phase A: i_ce high every clock ----------------
    rst_n = 1'b1;
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0; cnt_e = 0; cnt_f = 0;
    cnt_g = 0; cnt_h = 0; cnt_i = 0;
    first_a = 0; first_b = 0; first_c = 0; first_d = 0; first_e = 0;
    for (int e = 1; e <= 2100; e++) begin
      applyStimulus(1'b1);
      if (e == 1) begin
        checkOutput("first_fs",     32'(fs_d),  32'd1);
        checkOutput("first_ls",     32'(ls_d),  32'd1);
        checkOutput("first_active", 32'(act_d), 32'd1);
        checkOutput("first_blank",  32'(blank_d), 32'd0);
        checkOutput("first_xy",     32'({x_d, y_d}), 32'd0);
        checkOutput("first_fs_s",   32'(fs_s),  32'd1);
        checkOutput("first_fs_v",   32'(fs_v),  32'd1);
`ifdef VGA_TPG_EN
        checkOutput("tpg_x0",       32'(rgb_v), 32'h0000_0FFF);
`else
        checkOutput("rgb_off_v",    32'(rgb_v), 32'd0);
        checkOutput("rgb_off_d",    32'(rgb_d), 32'd0);
`endif
      end
      if (e == 2) begin
        checkOutput("fs_one_wide", 32'(fs_d), 32'd0);
        checkOutput("ls_one_wide", 32'(ls_d), 32'd0);
        checkOutput("x1",          32'(x_d),  32'd1);
      end
`ifdef VGA_TPG_EN
      if (e == 81)  checkOutput("tpg_x80",  32'(rgb_v), 32'h0000_0FF0);
      if (e == 640) checkOutput("tpg_x639", 32'(rgb_v), 32'd0);
`endif
      if (e == 800) begin
        checkOutput("x799",        32'(x_d),   32'd799);
        checkOutput("x799_active", 32'(act_d), 32'd1);
        checkOutput("v_ls_799",    32'(ls_v),  32'd0);
      end
      if (e == 801) begin
        checkOutput("x800_active", 32'(act_d),   32'd0);
        checkOutput("x800_blank",  32'(blank_d), 32'd1);
        checkOutput("x800_x",      32'(x_d),     32'd0);
        checkOutput("v_htotal800", 32'(ls_v),    32'd1);
      end
      if (e == 1041) begin
        checkOutput("line1_ls",  32'(ls_d),  32'd1);
        checkOutput("line1_y",   32'(y_d),   32'd1);
        checkOutput("line1_irq", 32'(li_d),  32'd1);
        checkOutput("line1_fs",  32'(fs_d),  32'd0);
      end
      if (e == 16)   checkOutput("s_x15",      32'({act_s, x_s}), 32'h0000_080F);
      if (e == 17)   checkOutput("s_x16",      32'({act_s, x_s}), 32'd0);
      if (e == 169)  checkOutput("s_y7",       32'({act_s, y_s}), 32'h0000_0407);
      if (e == 217)  checkOutput("s_y_clamp",  32'({act_s, y_s}), 32'd7);
      if (e == 240)  checkOutput("s_vs_pre",   32'(vs_s), 32'd0);
      if (e == 241)  checkOutput("s_vs_on",    32'(vs_s), 32'd1);
      if (e == 288)  checkOutput("s_vs_last",  32'(vs_s), 32'd1);
      if (e == 289)  checkOutput("s_vs_off",   32'(vs_s), 32'd0);
      if (e == 335)  checkOutput("s_frame0",   32'(frame_s), 32'd0);
      if (e == 336)  checkOutput("s_frame1",   32'(frame_s), 32'd1);
      if (e == 1343) checkOutput("s_frame3",   32'(frame_s), 32'd3);
      if (e == 1344) checkOutput("s_frame_wrap", 32'(frame_s), 32'd0);

      if (e <= 1040 && hs_d) cnt_a++;
      if (hs_d && first_a == 0) first_a = e;
      if (li_d) cnt_b++;
      if (vs_d || an_d || se_d) cnt_c++;
      if (fs_s) cnt_d++;
      if (se_s) begin
        cnt_e++;
        if (first_b == 0) first_b = e;
      end
      if (an_s) begin
        cnt_f++;
        if (first_c == 0) first_c = e;
      end
      if (li_s) begin
        cnt_g++;
        if (first_d == 0) first_d = e;
      end
      if (e <= 336 && vs_s) cnt_h++;
      if (e <= 800 && !hs_v) cnt_i++;
      if (!hs_v && first_e == 0) first_e = e;
    end
    checkOutput("hs_rise_at_856",  32'(first_a), 32'd857);
    checkOutput("hs_width_120",    32'(cnt_a),   32'd120);
    checkOutput("d_irq_once",      32'(cnt_b),   32'd1);
    checkOutput("d_no_vs_an_se",   32'(cnt_c),   32'd0);
    checkOutput("s_fs_count",      32'(cnt_d),   32'd7);
    checkOutput("s_se_count",      32'(cnt_e),   32'd6);
    checkOutput("s_se_first",      32'(first_b), 32'd336);
    checkOutput("s_an_count",      32'(cnt_f),   32'd6);
    checkOutput("s_an_first",      32'(first_c), 32'd184);
    checkOutput("s_irq_count",     32'(cnt_g),   32'd7);
    checkOutput("s_irq_first",     32'(first_d), 32'd73);
    checkOutput("s_vs_clocks",     32'(cnt_h),   32'd48);
    checkOutput("v_hs_low_width",  32'(cnt_i),   32'd96);
    checkOutput("v_hs_fall_656",   32'(first_e), 32'd657);
    checkOutput("d_frame_still0",  32'(frame_d), 32'd0);

    // ---------------- phase B: i_ce high every third clock ----------------
    resetDut();
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
    first_a = 0; first_b = 0;
    for (int c = 1; c <= 3125; c++) begin
      applyStimulus(c % 3 == 1);
      if (ls_d) begin
        cnt_a++;
        if (cnt_a == 1) first_a = c;
        if (cnt_a == 2) first_b = c;
      end
      if (fs_d) cnt_b++;
      if (c <= 3120 && hs_d) cnt_c++;
      if (fs_s) cnt_d++;
      if (c == 2) begin
        checkOutput("ce3_fs_cleared", 32'(fs_d),  32'd0);
        checkOutput("ce3_act_hold",   32'(act_d), 32'd1);
      end
      if (c == 4)  checkOutput("ce3_x1",      32'(x_d), 32'd1);
      if (c == 31) checkOutput("ce3_x10_a",   32'(x_d), 32'd10);
      if (c == 32) checkOutput("ce3_x10_b",   32'(x_d), 32'd10);
      if (c == 33) checkOutput("ce3_x10_c",   32'(x_d), 32'd10);
      if (c == 2568) checkOutput("ce3_hs_855", 32'(hs_d), 32'd0);
      if (c == 2569) checkOutput("ce3_hs_856a", 32'(hs_d), 32'd1);
      if (c == 2571) checkOutput("ce3_hs_856c", 32'(hs_d), 32'd1);
    end
    checkOutput("ce3_ls_count",  32'(cnt_a),           32'd2);
    checkOutput("ce3_ls_first",  32'(first_a),         32'd1);
    checkOutput("ce3_line_3120", 32'(first_b - first_a), 32'd3120);
    checkOutput("ce3_fs_count",  32'(cnt_b),           32'd1);
    checkOutput("ce3_hs_clocks", 32'(cnt_c),           32'd360);
    checkOutput("ce3_s_fs",      32'(cnt_d),           32'd4);

    // ---------------- phase C: raster-line interrupt programming ----------------
    irq_d = 10'd700;
    irq_s = 10'd700;
    resetDut();
    cnt_a = 0; cnt_b = 0; first_a = 0;
    for (int e = 1; e <= 1008; e++) begin
      applyStimulus(1'b1);
      if (li_s) begin
        cnt_a++;
        if (first_a == 0) first_a = e;
      end
      if (li_d) cnt_b++;
      if (e == 150) irq_s = 10'd5;
      if (e == 480) irq_s = 10'd14;
    end
    checkOutput("irq_change_count", 32'(cnt_a),   32'd1);
    checkOutput("irq_next_frame",   32'(first_a), 32'd457);
    checkOutput("irq_700_never",    32'(cnt_b),   32'd0);

    // ---------------- phase D: asynchronous reset mid-line ----------------
    resetDut();
    for (int e = 1; e <= 401; e++) applyStimulus(1'b1);
    checkOutput("pre_rst_x400",   32'(x_d),     32'd400);
    checkOutput("pre_rst_frame",  32'(frame_s), 32'd1);
    rst_n = 1'b0;
    #2;
    checkOutput("async_active", 32'(act_d),   32'd0);
    checkOutput("async_blank",  32'(blank_d), 32'd1);
    checkOutput("async_x",      32'(x_d),     32'd0);
    checkOutput("async_s_y",    32'(y_s),     32'd0);
    checkOutput("async_s_frame", 32'(frame_s), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1);
    checkOutput("restart_fs",     32'(fs_d),  32'd1);
    checkOutput("restart_xy",     32'({x_d, y_d}), 32'd0);
    checkOutput("restart_active", 32'(act_d), 32'd1);
    checkOutput("restart_s_fs",   32'(fs_s),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/SVGA raster timing generator; the next generation of the fixed 800x600 driver.
- Sits between the board clock domain and the pixel renderer. Supplies sync, blanking, coordinates, frame/line strobes and a programmable raster-line interrupt.
- Adds a pixel clock-enable, sync polarity control, registered outputs and a frame counter.
- Default timing is 800x600 (1040x666 total) at 50 MHz.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, horizontal sync width (pixels)
- H_BP, 64, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, hsync active level (1 = active-high)
- VS_POL, 1, vsync active level (1 = active-high)
- X_W, 11, width of o_x and of the internal h counter
- Y_W, 10, width of o_y, i_irq_line and of the internal v counter
- FRAME_W, 16, width of o_frame

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_ce  in  1  pixel clock-enable; the raster advances only when high
- i_irq_line  in  Y_W  raster line that fires o_line_irq
- o_hs  out  1  horizontal sync, polarity HS_POL
- o_vs  out  1  vertical sync, polarity VS_POL
- o_active  out  1  current pixel is visible
- o_blanking  out  1  inverse of o_active
- o_x  out  X_W  pixel column; 0 outside the active area
- o_y  out  Y_W  pixel line; clamped to V_ACTIVE-1 outside the active lines
- o_line_start  out  1  pulse: pixel h=0
- o_frame_start  out  1  pulse: pixel (0,0)
- o_animate  out  1  pulse: last active pixel (H_ACTIVE-1, V_ACTIVE-1)
- o_screenend  out  1  pulse: last pixel of the frame (H_TOTAL-1, V_TOTAL-1)
- o_line_irq  out  1  pulse: pixel (0, i_irq_line)
- o_frame  out  FRAME_W  completed-frame count
- o_rgb  out  12  test-pattern colour, 4:4:4

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Line order is active, front porch, sync, back porch. Hsync is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on v.
- Counters h and v: on each clock with i_ce=1, h increments. At H_TOTAL-1, h becomes 0 and v increments. At (H_TOTAL-1, V_TOTAL-1), both become 0 and o_frame increments, wrapping modulo 2^FRAME_W.
- When i_ce=0, the counters hold.
- Output stage: on a clock with i_ce=1, all outputs register the decode of the current (h,v) in the same edge that advances the counters. Outputs therefore describe the pixel just issued, with one clock of latency from the counter.
- Level outputs (o_hs, o_vs, o_active, o_blanking, o_x, o_y, o_rgb) hold while i_ce=0.
- Pulse outputs (line_start, frame_start, animate, screenend, line_irq) are exactly one i_clk wide. They are cleared on the next clock whether or not i_ce is high.
- o_line_irq: i_irq_line is compared at h=0. A value >= V_TOTAL never fires. Changing i_irq_line mid-frame takes effect at the next line start.
- Reset (async, any time, including mid-line):
  - h=0, v=0, o_frame=0.
  - o_hs=!HS_POL, o_vs=!VS_POL.
  - o_active=0, o_blanking=1, o_x=0, o_y=0, o_rgb=0, all pulses 0.
  - The first i_ce=1 clock after release outputs pixel (0,0) with o_frame_start=1, o_line_start=1 and o_active=1.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. X_W and Y_W must cover the totals; this is checked by a simulation-only assertion.

Optional Feature:
- Macro: VGA_TPG_EN.
- Defined: o_rgb carries 8 vertical colour bars during the active area, each H_ACTIVE/8 wide. Bar k = {R,G,B} with each channel 4'hF if bit (2,1,0) of (7-k) is set, else 0; bar 0 is white, bar 7 is black. o_rgb = 0 during blanking.
- Undefined: o_rgb tied to 0 and no bar logic is synthesised.

Test Plan:
- Reset release, i_ce=1 constant, defaults:
  - first output pixel is (0,0) with o_frame_start=1;
  - o_hs rises at output pixel h=856 and stays high for 120 clocks;
  - o_vs is high for lines 637..642.
- Full frame: o_screenend and o_frame_start are 692640 clocks apart; o_frame counts 0→1→2 over two frames; o_animate is seen once per frame at (799,599).
- i_ce=1 every third clock: line period 3120 clocks; pulses are one i_clk wide; level outputs are stable between enables.
- i_irq_line:
  - 100: o_line_irq fires exactly once per frame at (0,100);
  - 700: never fires;
  - changed to 5 at line 50: the next fire is in the following frame.
- i_rst_n asserted mid-line at h=400, v=300: outputs clear without a clock edge; after release, counting restarts at (0,0).
- Non-default HS_POL=0, H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48: o_hs is low for h 656..751; H_TOTAL is 800. With VGA_TPG_EN, o_rgb is 12'hFFF at x=0 and 12'h000 at x=639.
